// File: rtl/pulse_seq_pkg.sv
// Shared types and constants for the pulse sequencer: state encoding,
// counter sizing and the power-on values of the parameter shadows.
package pulse_seq_pkg;

    localparam int CNT_W   = 32;
    localparam int MIN_PER = 2;

    typedef enum logic [2:0] {
        IDLE,
        P1,
        GAP1,
        P2,
        GAP2,
        TAIL,
        WAIT
    } state_t;

    localparam int DEF_PER      = 15;
    localparam int DEF_P1WID    = 30;
    localparam int DEF_DEL      = 200;
    localparam int DEF_P2WID    = 30;
    localparam int DEF_CP       = 3;
    localparam int DEF_P_BL_OFF = 100;
    localparam logic DEF_PU     = 1'b1;
    localparam logic DEF_BL     = 1'b1;

endpackage

// File: rtl/pulse_period_timer.sv
// Free-running period counter with MIN_PER clamp; flags the upcoming T0
// one cycle ahead and registers it as the sync strobe.
module pulse_period_timer
#(
    parameter int CNT_W   = pulse_seq_pkg::CNT_W,
    parameter int MIN_PER = pulse_seq_pkg::MIN_PER
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] per,
    output logic             t0_next,
    output logic             sync
);
    import pulse_seq_pkg::*;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic             run;

    // A fresh enable starts a period immediately; otherwise wrap at last count.
    always_comb begin
        last    = (per < CNT_W'(MIN_PER)) ? CNT_W'(MIN_PER - 1) : per - CNT_W'(1);
        t0_next = en && (!run || cnt == last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            run  <= 1'b0;
            sync <= 1'b0;
        end else begin
            run  <= en;
            sync <= t0_next;
            if (!en || t0_next)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pulse_sequencer.sv
// Hahn-echo / CPMG gate sequencer: shadowed parameters applied atomically at
// period boundaries, zero-length phases skipped by look-ahead.
module pulse_sequencer
#(
    parameter int CNT_W   = pulse_seq_pkg::CNT_W,
    parameter int MIN_PER = pulse_seq_pkg::MIN_PER
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] per,
    input  logic [CNT_W-1:0] p1wid,
    input  logic [CNT_W-1:0] del,
    input  logic [CNT_W-1:0] p2wid,
    input  logic [7:0]       cp,
    input  logic             pu,
    input  logic             bl,
    input  logic [15:0]      p_bl_off,
    input  logic             rxd,
    output logic             sync,
    output logic             pulse,
    output logic             rx_blank,
    output logic             busy,
    output logic             cfg_ack,
    output logic             overrun
);
    import pulse_seq_pkg::*;

    state_t           state, nxt;
    logic [CNT_W:0]   ph, nph;
    logic [7:0]       rem, nrem, rem_w;

    logic [CNT_W-1:0] sh_per, sh_p1wid, sh_del, sh_p2wid;
    logic [7:0]       sh_cp;
    logic             sh_pu, sh_bl;
    logic [15:0]      sh_pbo;

    logic             rxd_q, pend, rise, load, ack_nxt, ovr_set, t0_next;
    logic [CNT_W-1:0] e_p1, e_del, e_p2;
    logic [CNT_W:0]   e_d2;
    logic [7:0]       e_cp;
    logic             e_pu, e_bl;
    logic [15:0]      e_pbo;
    logic             try_p1, try_gap1, try_p2, try_gap2, try_tail;

    function automatic logic [CNT_W:0] len_m1(input logic [CNT_W:0] len);
        return len - (CNT_W+1)'(1);
    endfunction

    pulse_period_timer #(.CNT_W(CNT_W), .MIN_PER(MIN_PER)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .per     (sh_per),
        .t0_next (t0_next),
        .sync    (sync)
    );

    // Parameters seen by next-state logic: the values the shadows will hold next cycle.
    always_comb begin
        rise    = rxd && !rxd_q;
        load    = t0_next && (state == IDLE || pend || rise);
        ack_nxt = t0_next && (pend || rise);
        ovr_set = t0_next && state != IDLE && state != WAIT;
        e_p1    = load ? p1wid    : sh_p1wid;
        e_del   = load ? del      : sh_del;
        e_p2    = load ? p2wid    : sh_p2wid;
        e_cp    = load ? cp       : sh_cp;
        e_pu    = load ? pu       : sh_pu;
        e_bl    = load ? bl       : sh_bl;
        e_pbo   = load ? p_bl_off : sh_pbo;
        e_d2    = {e_del, 1'b0};
    end

    always_comb begin
        nxt      = state;
        nph      = (ph != '0) ? ph - (CNT_W+1)'(1) : '0;
        rem_w    = rem;
        try_p1   = 1'b0;
        try_gap1 = 1'b0;
        try_p2   = 1'b0;
        try_gap2 = 1'b0;
        try_tail = 1'b0;
        if (!en) begin
            nxt = IDLE;
        end else if (t0_next) begin
            try_p1 = 1'b1;
            rem_w  = e_cp;
        end else if (ph == '0) begin
            case (state)
                P1:      if (e_cp == 8'd0) try_tail = 1'b1; else try_gap1 = 1'b1;
                GAP1:    try_p2 = 1'b1;
                P2:      if (rem != 8'd0) try_gap2 = 1'b1; else try_tail = 1'b1;
                GAP2:    try_p2 = 1'b1;
                TAIL:    nxt = WAIT;
                default: ;
            endcase
        end
        nrem = rem_w;

        // Resolve entry points in sequence order so zero-length phases fall through.
        if (try_p1) begin
            if (e_p1 != '0) begin
                nxt = P1;
                nph = len_m1({1'b0, e_p1});
            end else if (e_cp == 8'd0) begin
                try_tail = 1'b1;
            end else begin
                try_gap1 = 1'b1;
            end
        end
        if (try_gap1) begin
            if (e_del != '0) begin
                nxt = GAP1;
                nph = len_m1({1'b0, e_del});
            end else begin
                try_p2 = 1'b1;
            end
        end
        if (try_gap2) begin
            if (e_d2 != '0) begin
                nxt = GAP2;
                nph = len_m1(e_d2);
            end else begin
                try_p2 = 1'b1;
            end
        end
        if (try_p2) begin
            nrem = rem_w - 8'd1;
            if (e_p2 != '0) begin
                nxt = P2;
                nph = len_m1({1'b0, e_p2});
            end else if (rem_w != 8'd1 && e_d2 != '0) begin
                nxt = GAP2;
                nph = len_m1(e_d2);
            end else begin
                try_tail = 1'b1;
            end
        end
        if (try_tail) begin
            if (e_pbo != 16'd0) begin
                nxt = TAIL;
                nph = len_m1((CNT_W+1)'(e_pbo));
            end else begin
                nxt = WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ph       <= '0;
            rem      <= '0;
            rxd_q    <= 1'b0;
            pend     <= 1'b0;
            pulse    <= 1'b0;
            rx_blank <= 1'b0;
            busy     <= 1'b0;
            cfg_ack  <= 1'b0;
            overrun  <= 1'b0;
            sh_per   <= CNT_W'(DEF_PER);
            sh_p1wid <= CNT_W'(DEF_P1WID);
            sh_del   <= CNT_W'(DEF_DEL);
            sh_p2wid <= CNT_W'(DEF_P2WID);
            sh_cp    <= 8'(DEF_CP);
            sh_pu    <= DEF_PU;
            sh_bl    <= DEF_BL;
            sh_pbo   <= 16'(DEF_P_BL_OFF);
        end else begin
            state    <= nxt;
            ph       <= nph;
            rem      <= nrem;
            rxd_q    <= rxd;
            pend     <= ack_nxt ? 1'b0 : (rise ? 1'b1 : pend);
            pulse    <= (nxt == P1 && e_pu) || nxt == P2;
            rx_blank <= e_bl && (nxt inside {P1, GAP1, P2, GAP2, TAIL});
            busy     <= nxt != IDLE;
            cfg_ack  <= ack_nxt;
            // An applied update clears the flag even if that same wrap truncated the old sequence.
            overrun  <= ack_nxt ? 1'b0 : (ovr_set ? 1'b1 : overrun);
            if (load) begin
                sh_per   <= per;
                sh_p1wid <= p1wid;
                sh_del   <= del;
                sh_p2wid <= p2wid;
                sh_cp    <= cp;
                sh_pu    <= pu;
                sh_bl    <= bl;
                sh_pbo   <= p_bl_off;
            end
        end
    end

endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Cycle-accurate pulse sequencer driven by the UART parameter registers (period, pulse widths, delay, CPMG count, pump, block). Generates a Hahn-echo/CPMG gate train each period, plus a period sync strobe and a receiver-blanking gate. Parameter updates announced by the command decoder's `rxd` strobe are held pending and applied atomically at the next period boundary, so no period is ever built from mixed old and new values. Sits between the command decoder and the RF switch / receiver protection pins.

## Interface
- `CNT_W`, 32: width of all cycle counters.
- `MIN_PER`, 2: minimum effective period in cycles. Smaller `per` values are clamped to this.
- `clk` in 1: system clock, 201 MHz.
- `rst_n` in 1: asynchronous active-low reset.
- `en` in 1: run enable. Level sensitive.
- `per` in 32: period length, in cycles.
- `p1wid` in 32: pulse 1 width, in cycles.
- `del` in 32: delay from end of P1 to start of first P2, in cycles.
- `p2wid` in 32: pulse 2 width, in cycles.
- `cp` in 8: number of P2 pulses. 0 means P1 only.
- `pu` in 1: P1 output enable. P1 timing runs regardless.
- `bl` in 1: blanking enable.
- `p_bl_off` in 16: blanking tail after the last pulse, in cycles.
- `rxd` in 1: new-parameter strobe. Its rising edge is used.
- `sync` out 1: high for exactly the first cycle (T0) of each period.
- `pulse` out 1: RF gate.
- `rx_blank` out 1: receiver blanked when high.
- `busy` out 1: high when the state is not IDLE.
- `cfg_ack` out 1: one-cycle pulse at the T0 where pending parameters are applied.
- `overrun` out 1: sticky; the sequence was truncated by a period wrap.

## Operation
- Shadow registers hold all parameter inputs. The sequencer only ever reads shadows.
- Shadows load unconditionally on the IDLE→T0 transition. After that, a shadow load happens at T0 only when the pending flag is set.
- Pending flag:
  - Set the cycle after an `rxd` rising edge is registered.
  - Cleared at the T0 that loads the shadows; `cfg_ack`=1 in that same cycle.
  - An edge whose pending flag is set in the same cycle as a T0 is applied at that T0.
  - Multiple edges within one period collapse into a single update.
- Period timer: counts 0..max(per,MIN_PER)−1 and wraps. Count 0 is T0.
- States: IDLE, P1, GAP1, P2, GAP2, TAIL, WAIT.
  - IDLE → P1 at T0 when `en`=1.
  - P1 lasts p1wid cycles, then → GAP1.
  - GAP1 lasts del cycles, then → P2. If cp=0, GAP1 is skipped and P1 goes → TAIL.
  - P2 lasts p2wid cycles. Then → GAP2 if echoes remain, else → TAIL.
  - GAP2 lasts 2·del cycles, computed with 33-bit arithmetic and no saturation below 2^33; then → P2.
  - TAIL lasts p_bl_off cycles, then → WAIT.
  - WAIT → P1 at the next T0.
- Any phase with a zero count occupies zero cycles: next-state logic looks ahead and skips it.
- Outputs:
  - `pulse` = 1 in P1 when `pu`=1, and in every P2.
  - `rx_blank` = `bl` in states P1 through TAIL, otherwise 0.
- Period wrap while in any state other than WAIT:
  - Sets `overrun`.
  - Aborts the current sequence.
  - That T0 starts P1 normally.
- `overrun` clears on `cfg_ack` or reset.
- `en` deasserted in any state: next cycle goes to IDLE, `pulse`=0, `rx_blank`=0, and the period timer holds at 0.
- Reset values: `sync`=0, `pulse`=0, `rx_blank`=0, `busy`=0, `cfg_ack`=0, `overrun`=0. State=IDLE, timer=0, pending=0. Shadows hold stp defaults (per 15, p1wid 30, del 200, p2wid 30, cp 3, pu 1, bl 1, p_bl_off 100).

## Timing
- All outputs are registered.
- Waveform relative to T0 (the cycle where `sync`=1), with W1=p1wid, D=del, W2=p2wid:
  - `pulse` high over [T0, T0+W1−1].
  - First P2 starts at T0+W1+D.
  - The k-th P2 (k from 0) starts at T0+W1+D+k·(W2+2D).
- `rx_blank` falls p_bl_off cycles after the last `pulse` high cycle.
- `en` rise at cycle N gives the first T0 at N+1.
- `rxd` rise sampled at N sets pending at N+1.
- Async reset asserted mid-pulse forces `pulse`=0 immediately, with no clock required.

## Structure
- Package `pulse_seq_pkg` holds:
  - The state enum.
  - `CNT_W`, `MIN_PER`.
  - The reset-default constants for the shadows.
- Sub-module `pulse_period_timer` contains:
  - The period counter.
  - The clamp.
  - The `sync`/T0 generation.
  - The hold-at-0 behaviour when disabled.
- The state machine, shadows, pending logic and output logic stay in `pulse_sequencer`.

## Test plan
- Base echo: per=100, p1wid=3, del=5, p2wid=4, cp=1, pu=1, bl=1, p_bl_off=2, en=1.
  - `pulse` high at T0..T0+2 and at T0+8..T0+11.
  - `rx_blank` high T0..T0+13.
  - `sync` every 100 cycles.
- CPMG: same settings with cp=3. P2 starts at T0+8, T0+22 and T0+36; `overrun`=0.
- Zero widths and edge settings:
  - p1wid=0 gives no P1 pulse; P2 starts at T0+5.
  - cp=0 gives a single P1 only.
  - per=1 gives a period of 2.
- Overrun: per=20, cp=3.
  - `overrun` sets at the wrap.
  - The next T0 restarts P1.
  - `overrun` clears on the following `cfg_ack`.
- Atomic update: pulse `rxd` mid-period with new p1wid=10.
  - The current period keeps p1wid=3.
  - `cfg_ack` fires at the next T0 and that period shows a 10-cycle P1.
  - Two `rxd` edges in one period produce one `cfg_ack`.
- Reset and enable:
  - Drop `en` inside P2: `pulse`=0 next cycle and `busy`=0.
  - Assert `rst_n` low mid-pulse: all outputs 0 asynchronously, and shadows return to defaults.
